// File: rtl/branch_pkg.sv
// Shared constants and helpers for the branch resolve unit: condition codes,
// 2-bit counter states and condition-flag bit positions.
package branch_pkg;

  localparam logic [2:0] COND_LT = 3'b000;
  localparam logic [2:0] COND_GT = 3'b001;
  localparam logic [2:0] COND_LE = 3'b010;
  localparam logic [2:0] COND_GE = 3'b011;
  localparam logic [2:0] COND_EQ = 3'b100;
  localparam logic [2:0] COND_NE = 3'b101;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam int FLAG_LT = 0;
  localparam int FLAG_GT = 1;
  localparam int FLAG_LE = 2;
  localparam int FLAG_GE = 3;
  localparam int FLAG_EQ = 4;
  localparam int FLAG_NE = 5;

  // Codes 110/111 are reserved and never match.
  function automatic logic condMatch(input logic [2:0] cond, input logic [5:0] flags);
    logic match;
    match = 1'b0;
    case (cond)
      COND_LT: match = flags[FLAG_LT];
      COND_GT: match = flags[FLAG_GT];
      COND_LE: match = flags[FLAG_LE];
      COND_GE: match = flags[FLAG_GE];
      COND_EQ: match = flags[FLAG_EQ];
      COND_NE: match = flags[FLAG_NE];
      default: match = 1'b0;
    endcase
    return match;
  endfunction

  function automatic logic [1:0] satUpdate(input logic [1:0] ctr, input logic taken);
    logic [1:0] nextCtr;
    nextCtr = ctr;
    if (taken && ctr != CTR_ST) nextCtr = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) nextCtr = ctr - 2'd1;
    return nextCtr;
  endfunction

endpackage

// File: rtl/bht_table.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port (returns the pre-update value on a same-cycle hit) and one update port.
module bht_table
  import branch_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rdIdx,
  output logic [1:0]       rdCtr,
  input  logic             updEn,
  input  logic [IDX_W-1:0] updIdx,
  input  logic             updTaken
);

  logic [1:0] ctr [ENTRIES];

  assign rdCtr = ctr[rdIdx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) ctr[i] <= CTR_WNT;
    end else if (updEn) begin
      ctr[updIdx] <= satUpdate(ctr[updIdx], updTaken);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves jumps/conditional branches in execute, detects mispredicts, holds a
// flush window after each redirect and keeps branch/mispredict statistics.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int PC_W         = 16,
  parameter int BHT_ENTRIES  = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int STAT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_valid,
  input  logic [PC_W-1:0]   f_pc,
  output logic              f_pred_taken,
  input  logic              ex_valid,
  input  logic [PC_W-1:0]   ex_pc,
  input  logic              ex_jump,
  input  logic              ex_branch,
  input  logic [2:0]        ex_cond,
  input  logic [5:0]        ex_flags,
  input  logic              ex_pred_taken,
  output logic              select_jb,
  output logic              redirect,
  output logic              redirect_fallthru,
  output logic              flush,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispred
);

  localparam int IDX_W  = $clog2(BHT_ENTRIES);
  localparam int HOLD_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [HOLD_W-1:0] holdCnt;
  logic [1:0]        fetchCtr;
  logic              live;
  logic              isCondBranch;
  logic              taken;
  logic              bhtUpdate;

  bht_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) uBht (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdIdx    (f_pc[IDX_W:1]),
    .rdCtr    (fetchCtr),
    .updEn    (bhtUpdate),
    .updIdx   (ex_pc[IDX_W:1]),
    .updTaken (taken)
  );

  logic unusedPcBits;
  assign unusedPcBits = ^{f_pc[PC_W-1:IDX_W+1], f_pc[0], ex_pc[PC_W-1:IDX_W+1], ex_pc[0]};

  // A jump wins over a simultaneous branch flag, so it never trains the table.
  always_comb begin
    live              = ex_valid & (holdCnt == '0);
    isCondBranch      = ex_branch & ~ex_jump;
    taken             = ex_jump | (isCondBranch & condMatch(ex_cond, ex_flags));
    select_jb         = live & taken;
    redirect          = live & (ex_jump | ex_branch) & (select_jb != ex_pred_taken);
    redirect_fallthru = redirect & ~select_jb;
    flush             = redirect | (holdCnt != '0);
    bhtUpdate         = live & isCondBranch;
    f_pred_taken      = f_valid & fetchCtr[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdCnt       <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
    end else begin
      if (redirect) holdCnt <= HOLD_W'(FLUSH_CYCLES - 1);
      else if (holdCnt != '0) holdCnt <= holdCnt - HOLD_W'(1);
      if (bhtUpdate) stat_branches <= stat_branches + STAT_W'(1);
      if (redirect) stat_mispred <= stat_mispred + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// then random stimulus against a behavioural model of the unit.
module tb_branch_resolve_unit;

  localparam int STAT_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              f_valid;
  logic [15:0]       f_pc;
  logic              f_pred_taken;
  logic              ex_valid;
  logic [15:0]       ex_pc;
  logic              ex_jump;
  logic              ex_branch;
  logic [2:0]        ex_cond;
  logic [5:0]        ex_flags;
  logic              ex_pred_taken;
  logic              select_jb;
  logic              redirect;
  logic              redirect_fallthru;
  logic              flush;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  int total = 0;
  int bad   = 0;

  // Behavioural model state
  int mCtr [16];
  int mHold;
  int mBranches;
  int mMispred;

  typedef struct {
    logic        fValid;
    logic [15:0] fPc;
    logic        exValid;
    logic [15:0] exPc;
    logic        exJump;
    logic        exBranch;
    logic [2:0]  exCond;
    logic [5:0]  exFlags;
    logic        exPred;
    logic        eFPred;
    logic        eSel;
    logic        eRed;
    logic        eFall;
    logic        eFlush;
    int          eStatB;
    int          eStatM;
  } vec_t;

  vec_t vecs[$];

  branch_resolve_unit #(
    .PC_W         (16),
    .BHT_ENTRIES  (16),
    .FLUSH_CYCLES (2),
    .STAT_W       (STAT_W)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .f_valid           (f_valid),
    .f_pc              (f_pc),
    .f_pred_taken      (f_pred_taken),
    .ex_valid          (ex_valid),
    .ex_pc             (ex_pc),
    .ex_jump           (ex_jump),
    .ex_branch         (ex_branch),
    .ex_cond           (ex_cond),
    .ex_flags          (ex_flags),
    .ex_pred_taken     (ex_pred_taken),
    .select_jb         (select_jb),
    .redirect          (redirect),
    .redirect_fallthru (redirect_fallthru),
    .flush             (flush),
    .stat_branches     (stat_branches),
    .stat_mispred      (stat_mispred)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic fv, input logic [15:0] fp, input logic ev,
                              input logic [15:0] ep, input logic j, input logic b,
                              input logic [2:0] c, input logic [5:0] fl, input logic p,
                              input logic efp, input logic es, input logic er,
                              input logic ef, input logic efl, input int sb, input int sm);
    vec_t v;
    v.fValid = fv;  v.fPc = fp;  v.exValid = ev;  v.exPc = ep;
    v.exJump = j;   v.exBranch = b;  v.exCond = c;  v.exFlags = fl;  v.exPred = p;
    v.eFPred = efp; v.eSel = es; v.eRed = er; v.eFall = ef; v.eFlush = efl;
    v.eStatB = sb;  v.eStatM = sm;
    return v;
  endfunction

  function automatic vec_t idle(input logic fv, input logic [15:0] fp);
    return mk(fv, fp, 0, 16'h0, 0, 0, 3'b000, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 16; i++) mCtr[i] = 1;
    mHold = 0;
    mBranches = 0;
    mMispred = 0;
  endtask

  task automatic driveInputs(input vec_t v);
    f_valid = v.fValid;   f_pc = v.fPc;
    ex_valid = v.exValid; ex_pc = v.exPc;
    ex_jump = v.exJump;   ex_branch = v.exBranch;
    ex_cond = v.exCond;   ex_flags = v.exFlags;
    ex_pred_taken = v.exPred;
  endtask

  // Drive one cycle, compare outputs (table or model), then advance the model.
  task automatic applyStimulus(input vec_t v, input bit useModel, input string tag);
    bit live, isBr, match, tk, eSel, eRed, eFall, eFlush, eFPred;
    int idx;
    @(negedge clk);
    driveInputs(v);
    #1;
    live   = v.exValid && (mHold == 0);
    isBr   = v.exBranch && !v.exJump;
    match  = (v.exCond < 6) && v.exFlags[v.exCond];
    tk     = v.exJump || (isBr && match);
    eSel   = live && tk;
    eRed   = live && (v.exJump || v.exBranch) && (eSel != v.exPred);
    eFall  = eRed && !eSel;
    eFlush = eRed || (mHold != 0);
    eFPred = v.fValid && (mCtr[(v.fPc / 2) % 16] >= 2);
    if (useModel) begin
      checkOutput({tag, ".fPred"}, f_pred_taken, eFPred);
      checkOutput({tag, ".select"}, select_jb, eSel);
      checkOutput({tag, ".redirect"}, redirect, eRed);
      checkOutput({tag, ".fallthru"}, redirect_fallthru, eFall);
      checkOutput({tag, ".flush"}, flush, eFlush);
      checkOutput({tag, ".statB"}, stat_branches, mBranches % 16);
      checkOutput({tag, ".statM"}, stat_mispred, mMispred % 16);
    end else begin
      checkOutput({tag, ".fPred"}, f_pred_taken, v.eFPred);
      checkOutput({tag, ".select"}, select_jb, v.eSel);
      checkOutput({tag, ".redirect"}, redirect, v.eRed);
      checkOutput({tag, ".fallthru"}, redirect_fallthru, v.eFall);
      checkOutput({tag, ".flush"}, flush, v.eFlush);
      checkOutput({tag, ".statB"}, stat_branches, v.eStatB);
      checkOutput({tag, ".statM"}, stat_mispred, v.eStatM);
    end
    if (live && isBr) begin
      idx = (v.exPc / 2) % 16;
      if (tk) mCtr[idx] = (mCtr[idx] == 3) ? 3 : mCtr[idx] + 1;
      else    mCtr[idx] = (mCtr[idx] == 0) ? 0 : mCtr[idx] - 1;
      mBranches++;
    end
    if (eRed) begin
      mMispred++;
      mHold = 1;
    end else if (mHold > 0) begin
      mHold--;
    end
  endtask

  initial begin
    vec_t v;
    rst_n = 1'b0;
    driveInputs(idle(0, 16'h0));
    resetModel();

    // fv fpc    ev ep     j b cond    flags      p | fP sel red fall fl  B  M
    vecs.push_back(idle(1, 16'h0010));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h0010, 0, 1, 3'b100, 6'b010000, 0, 0, 1, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1, 16'h0010, 0, 16'h0000, 0, 0, 3'b000, 6'h00,     0, 1, 0, 0, 0, 1, 1, 1));
    vecs.push_back(mk(1, 16'h0010, 0, 16'h0000, 0, 0, 3'b000, 6'h00,     0, 1, 0, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 16'h0004, 1, 16'h0004, 0, 1, 3'b000, 6'b000001, 1, 0, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 16'h0004, 0, 16'h0000, 0, 0, 3'b000, 6'h00,     0, 1, 0, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 16'h0004, 1, 16'h0004, 0, 1, 3'b000, 6'b000001, 1, 1, 1, 0, 0, 0, 2, 1));
    vecs.push_back(mk(1, 16'h0004, 0, 16'h0000, 0, 0, 3'b000, 6'h00,     0, 1, 0, 0, 0, 0, 3, 1));
    vecs.push_back(mk(1, 16'h0004, 1, 16'h0004, 0, 1, 3'b000, 6'b000001, 1, 1, 1, 0, 0, 0, 3, 1));
    vecs.push_back(mk(1, 16'h0004, 0, 16'h0000, 0, 0, 3'b000, 6'h00,     0, 1, 0, 0, 0, 0, 4, 1));
    vecs.push_back(mk(1, 16'h0004, 1, 16'h0004, 0, 1, 3'b000, 6'b000000, 1, 1, 0, 1, 1, 1, 4, 1));
    vecs.push_back(mk(1, 16'h0004, 0, 16'h0000, 0, 0, 3'b000, 6'h00,     0, 1, 0, 0, 0, 1, 5, 2));
    vecs.push_back(mk(1, 16'h0004, 1, 16'h0004, 0, 1, 3'b000, 6'b000000, 0, 1, 0, 0, 0, 0, 5, 2));
    vecs.push_back(mk(1, 16'h0004, 0, 16'h0000, 0, 0, 3'b000, 6'h00,     0, 0, 0, 0, 0, 0, 6, 2));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h0020, 0, 1, 3'b110, 6'b111111, 1, 0, 0, 1, 1, 1, 6, 2));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h0030, 1, 0, 3'b000, 6'h00,     0, 0, 0, 0, 0, 1, 7, 3));
    vecs.push_back(mk(0, 16'h0000, 1, 16'h0006, 1, 1, 3'b110, 6'h00,     0, 0, 1, 1, 0, 1, 7, 3));
    vecs.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 3'b000, 6'h00,     0, 0, 0, 0, 0, 1, 7, 4));
    vecs.push_back(mk(1, 16'h0006, 1, 16'h0006, 0, 1, 3'b100, 6'b010000, 1, 0, 1, 0, 0, 0, 7, 4));
    vecs.push_back(mk(1, 16'h0006, 0, 16'h0000, 0, 0, 3'b000, 6'h00,     0, 1, 0, 0, 0, 0, 8, 4));

    #3;
    checkOutput("resetFlush", flush, 0);
    checkOutput("resetStatB", stat_branches, 0);
    checkOutput("resetStatM", stat_mispred, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], 1'b0, $sformatf("row%0d", i));

    $display("[TB] statistics wrap");
    for (int i = 0; i < 8; i++)
      applyStimulus(mk(0, 0, 1, 16'h0008, 0, 1, 3'b111, 6'h3f, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, "wrap");
    applyStimulus(idle(0, 16'h0), 1'b1, "wrapIdle");
    checkOutput("statWrap", stat_branches, 0);

    $display("[TB] reset during flush hold");
    applyStimulus(mk(0, 0, 1, 16'h0010, 1, 0, 3'b000, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0), 1'b1, "preRst");
    applyStimulus(idle(0, 16'h0), 1'b1, "holdRst");
    rst_n = 1'b0;
    #1;
    checkOutput("midRstFlush", flush, 0);
    checkOutput("midRstStatB", stat_branches, 0);
    checkOutput("midRstStatM", stat_mispred, 0);
    resetModel();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(idle(1, 16'h0010), 1'b1, "postRst");
    checkOutput("postRstFlush", flush, 0);

    $display("[TB] random stimulus against model");
    for (int i = 0; i < 600; i++) begin
      v = idle(0, 16'h0);
      v.exValid  = ($urandom_range(0, 9) < 8);
      v.exPc     = 16'($urandom_range(0, 7) * 2 + $urandom_range(0, 1) * 16'h0100);
      v.exJump   = ($urandom_range(0, 9) == 0);
      v.exBranch = ($urandom_range(0, 9) < 7);
      v.exCond   = 3'($urandom_range(0, 7));
      v.exFlags  = 6'($urandom);
      v.exPred   = 1'($urandom);
      v.fValid   = 1'($urandom);
      v.fPc      = ($urandom_range(0, 2) == 0) ? v.exPc : 16'($urandom);
      applyStimulus(v, 1'b1, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- PC_W, 16, program-counter width.
- BHT_ENTRIES, 16, branch-history-table entries; power of two, >= 2.
- FLUSH_CYCLES, 2, cycles the flush is held after a mispredict; >= 1.
- STAT_W, 16, width of the statistics counters.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, single clock; rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- f_valid, in, 1, fetch lookup valid.
- f_pc, in, PC_W, fetch PC.
- f_pred_taken, out, 1, predicted taken for f_pc.
- ex_valid, in, 1, execute-stage instruction valid.
- ex_pc, in, PC_W, execute-stage PC.
- ex_jump, in, 1, instruction is an unconditional jump.
- ex_branch, in, 1, instruction is a conditional branch.
- ex_cond, in, 3, condition field (instruction bits 2:0).
- ex_flags, in, 6, condition flags {NE,EQ,GE,LE,GT,LT}, bit 0 = LT.
- ex_pred_taken, in, 1, prediction carried with the instruction.
- select_jb, out, 1, resolved taken; steer PC to the jump/branch target.
- redirect, out, 1, mispredict; PC mux overrides the fetch PC this cycle.
- redirect_fallthru, out, 1, on redirect, 1 = fall-through PC, 0 = target.
- flush, out, 1, squash younger pipeline stages.
- stat_branches, out, STAT_W, resolved conditional branches.
- stat_mispred, out, STAT_W, mispredicted jumps and branches.

Function
REQ-003 Table index SHALL be pc[IDX_W:1], where IDX_W = log2(BHT_ENTRIES); instructions are 2-byte aligned.
REQ-004 Each entry SHALL be a 2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-005 f_pred_taken SHALL be combinational: counter[idx(f_pc)][1] when f_valid, else 0.
REQ-006 Condition match SHALL follow this table: 000 LT, 001 GT, 010 LE, 011 GE, 100 EQ, 101 NE. Codes 110 and 111 SHALL never match.
REQ-007 The unit SHALL be "live" when ex_valid = 1 and the hold counter = 0.
REQ-008 select_jb SHALL be combinational: live & (ex_jump | (ex_branch & condition match)).
REQ-009 redirect SHALL be combinational: live & (ex_jump | ex_branch) & (select_jb != ex_pred_taken).
REQ-010 redirect_fallthru SHALL equal redirect & ~select_jb.
REQ-011 If ex_jump and ex_branch are both 1, ex_jump SHALL take precedence.
- The instruction SHALL be treated as a jump.
- No table update and no branch count SHALL occur.
REQ-012 Table update SHALL happen at the clock edge when live & ex_branch: increment if taken, decrement if not, saturating at 11 and 00.
REQ-013 Jumps SHALL NOT update the table.
REQ-014 If a lookup and an update hit the same index in the same cycle, the lookup SHALL return the pre-update value.
REQ-015 flush SHALL equal redirect | (hold counter != 0).
REQ-016 On redirect, the hold counter SHALL load FLUSH_CYCLES-1.
- It SHALL decrement each cycle until 0.
- flush therefore stays high for exactly FLUSH_CYCLES cycles.
REQ-017 While the hold counter is nonzero, the ex_* inputs SHALL be ignored.
- No select_jb, redirect, update or statistics change SHALL occur.
REQ-018 stat_branches SHALL increment on every live conditional branch.
REQ-019 stat_mispred SHALL increment on every redirect.
REQ-020 Both statistics counters SHALL wrap modulo 2^STAT_W.

Reset
REQ-021 Asserting rst_n low SHALL asynchronously, including mid-flush, set:
- every table entry to 01;
- the hold counter to 0;
- stat_branches and stat_mispred to 0.
REQ-022 During reset, all combinational outputs SHALL evaluate to 0, since the inputs are required low.
REQ-023 There SHALL be no pending flush after reset release.

Structure
REQ-024 Package branch_pkg SHALL hold:
- the condition-code constants (COND_LT .. COND_NE);
- the counter-state constants (CTR_SNT, CTR_WNT, CTR_WT, CTR_ST);
- the flag bit positions.
REQ-025 The table SHALL be a sub-module, bht_table, with one combinational read port, one synchronous update port, and the async reset.
REQ-026 Condition decode, redirect logic, the hold counter and the statistics SHALL live in the top module.

Verification
REQ-027 Reset, then f_pc=0x0010, f_valid=1 -> f_pred_taken=0; stat_branches=0; stat_mispred=0; flush=0.
REQ-028 Branch at ex_pc=0x0010, ex_cond=100, ex_flags=EQ only, ex_pred_taken=0 -> same cycle: select_jb=1, redirect=1, redirect_fallthru=0, flush=1.
- flush stays high for 2 cycles.
- Entry 8 becomes 10.
- stat_mispred=1, stat_branches=1.
REQ-029 Three taken branches at ex_pc=0x0004, with cycles between them, then one not-taken -> entry 2 reads 01→10→11→11→10.
- f_pred_taken at 0x0004 reads 1 after the 1st update.
REQ-030 ex_pred_taken=1, ex_cond=110, all flags 1 -> select_jb=0, redirect=1, redirect_fallthru=1.
- In the next cycle, a valid jump is ignored: select_jb=0.
REQ-031 f_pc=ex_pc=0x0006 in the same cycle, with the entry at 01 and a taken branch -> f_pred_taken=0 that cycle and 1 the next.
REQ-032 With STAT_W=4, 16 live branches -> stat_branches wraps to 0.
- Asserting rst_n low during a flush hold clears flush immediately.
